// File: rtl/fnd_scan_ctrl.sv
// Eight-digit seven-segment scan controller: per-slot blank/drive sequencing,
// once-per-frame value snapshot and hex decode with leading-zero blanking.
module fnd_scan_ctrl #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int DIGITS    = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_value,
    input  logic [7:0]  i_dp,
    input  logic        i_lzb,
    output logic [7:0]  o_com,
    output logic [7:0]  o_seg,
    output logic [2:0]  o_digit_idx,
    output logic        o_frame_start
);

    localparam int                CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [2:0]        IDX_LAST  = 3'(DIGITS - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t           state, state_n;
    logic             run;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic             slot_edge, frame_n, lz_blank;
    logic [31:0]      snap_value;
    logic [7:0]       snap_dp;
    logic             snap_lzb;
    logic [3:0]       nib;
    logic [7:0]       com_n, seg_n;

    // Active-low g..a patterns for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        slot_edge = 1'b0;
        cnt_n     = cnt + CNT_W'(1);
        idx_n     = idx;
        // The first edge after reset opens slot 0 without advancing the scan.
        if (!run) begin
            cnt_n     = '0;
            idx_n     = '0;
            slot_edge = 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt_n     = '0;
            slot_edge = 1'b1;
            idx_n     = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end
        frame_n = slot_edge && (idx_n == 3'd0);

        state_n = state;
        if (slot_edge)
            state_n = BLANK;
        if (cnt_n == BLANK_END)
            state_n = DRIVE;

        nib      = 4'(snap_value >> {idx_n, 2'b00});
        lz_blank = snap_lzb && (idx_n != 3'd0);
        for (int k = 0; k < DIGITS; k++) begin
            if (3'(k) >= idx_n && snap_value[4*k +: 4] != 4'h0)
                lz_blank = 1'b0;
        end

        com_n = 8'hFF;
        seg_n = 8'hFF;
        if (state_n == DRIVE) begin
            com_n = ~(8'd1 << idx_n);
            seg_n = {~snap_dp[idx_n], lz_blank ? 7'h7F : hex7(nib)};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= BLANK;
            run           <= 1'b0;
            cnt           <= '0;
            idx           <= '0;
            snap_value    <= '0;
            snap_dp       <= '0;
            snap_lzb      <= 1'b0;
            o_com         <= 8'hFF;
            o_seg         <= 8'hFF;
            o_digit_idx   <= '0;
            o_frame_start <= 1'b0;
        end else begin
            state         <= state_n;
            run           <= 1'b1;
            cnt           <= cnt_n;
            idx           <= idx_n;
            o_com         <= com_n;
            o_seg         <= seg_n;
            o_digit_idx   <= idx_n;
            o_frame_start <= frame_n;
            if (frame_n) begin
                snap_value <= i_value;
                snap_dp    <= i_dp;
                snap_lzb   <= i_lzb;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with a small scan geometry (8 clocks/slot,
// 2 blank clocks, 4 digits); edges are counted from reset release.
module tb_fnd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        lzb;
    logic [7:0]  com, seg;
    logic [2:0]  digit_idx;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int         e;
        logic [7:0] com;
        logic [7:0] seg;
        logic [2:0] idx;
        logic       fs;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] seg_tab [16];

    fnd_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .DIGITS(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_value(value), .i_dp(dp), .i_lzb(lzb),
        .o_com(com), .o_seg(seg), .o_digit_idx(digit_idx),
        .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (edge %0d): got %02h expected %02h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input logic [7:0] s,
                           input logic [2:0] i, input logic f);
        chk({tag, ".com"}, com, c);
        chk({tag, ".seg"}, seg, s);
        chk({tag, ".idx"}, {5'd0, digit_idx}, {5'd0, i});
        chk({tag, ".fs"}, {7'd0, frame_start}, {7'd0, f});
    endtask

    task automatic adv_to(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            edge_cnt++;
        end
        #1;
    endtask

    task automatic do_reset(input logic [31:0] v, input logic [7:0] d, input logic l);
        rst   = 1'b1;
        value = v;
        dp    = d;
        lzb   = l;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'hFF, 8'hFF, 3'd0, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            adv_to(vq[i].e);
            chk_all(tag, vq[i].com, vq[i].seg, vq[i].idx, vq[i].fs);
        end
        vq.delete();
    endtask

    function automatic vec_t mk(input int e, input logic [7:0] c, input logic [7:0] s,
                                input logic [2:0] i, input logic f);
        vec_t v;
        v.e = e; v.com = c; v.seg = s; v.idx = i; v.fs = f;
        return v;
    endfunction

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        rst = 1'b1; value = '0; dp = '0; lzb = 1'b0;

        // Basic scan timing with 0x1234
        vq.push_back(mk(1,  8'hFF, 8'hFF, 3'd0, 1'b1));
        vq.push_back(mk(2,  8'hFF, 8'hFF, 3'd0, 1'b0));
        vq.push_back(mk(3,  8'hFE, 8'h99, 3'd0, 1'b0));
        vq.push_back(mk(8,  8'hFE, 8'h99, 3'd0, 1'b0));
        vq.push_back(mk(9,  8'hFF, 8'hFF, 3'd1, 1'b0));
        vq.push_back(mk(10, 8'hFF, 8'hFF, 3'd1, 1'b0));
        vq.push_back(mk(11, 8'hFD, 8'hB0, 3'd1, 1'b0));
        vq.push_back(mk(17, 8'hFF, 8'hFF, 3'd2, 1'b0));
        vq.push_back(mk(19, 8'hFB, 8'hA4, 3'd2, 1'b0));
        vq.push_back(mk(25, 8'hFF, 8'hFF, 3'd3, 1'b0));
        vq.push_back(mk(27, 8'hF7, 8'hF9, 3'd3, 1'b0));
        vq.push_back(mk(32, 8'hF7, 8'hF9, 3'd3, 1'b0));
        vq.push_back(mk(33, 8'hFF, 8'hFF, 3'd0, 1'b1));
        vq.push_back(mk(34, 8'hFF, 8'hFF, 3'd0, 1'b0));
        vq.push_back(mk(35, 8'hFE, 8'h99, 3'd0, 1'b0));
        vq.push_back(mk(64, 8'hF7, 8'hF9, 3'd3, 1'b0));
        vq.push_back(mk(65, 8'hFF, 8'hFF, 3'd0, 1'b1));
        do_reset(32'h0000_1234, 8'h00, 1'b0);
        run_vecs("scan");

        // Leading-zero blanking with a decimal point on digit 1
        vq.push_back(mk(3,  8'hFE, 8'hF8, 3'd0, 1'b0));
        vq.push_back(mk(11, 8'hFD, 8'h7F, 3'd1, 1'b0));
        vq.push_back(mk(19, 8'hFB, 8'hFF, 3'd2, 1'b0));
        vq.push_back(mk(27, 8'hF7, 8'hFF, 3'd3, 1'b0));
        do_reset(32'h0000_0007, 8'h02, 1'b1);
        run_vecs("lzb");

        // Mid-frame change is hidden; change on the frame-start edge is captured
        do_reset(32'h0000_1111, 8'h00, 1'b0);
        adv_to(10);
        value = 32'h0000_2222;
        adv_to(11); chk_all("snap.f0d1", 8'hFD, 8'hF9, 3'd1, 1'b0);
        adv_to(19); chk_all("snap.f0d2", 8'hFB, 8'hF9, 3'd2, 1'b0);
        adv_to(27); chk_all("snap.f0d3", 8'hF7, 8'hF9, 3'd3, 1'b0);
        adv_to(35); chk_all("snap.f1d0", 8'hFE, 8'hA4, 3'd0, 1'b0);
        adv_to(43); chk_all("snap.f1d1", 8'hFD, 8'hA4, 3'd1, 1'b0);
        adv_to(64);
        value = 32'h0000_3333;
        adv_to(65); chk_all("snap.edge", 8'hFF, 8'hFF, 3'd0, 1'b1);
        adv_to(67); chk_all("snap.f2d0", 8'hFE, 8'hB0, 3'd0, 1'b0);

        // Full hex decode on digit 0, one nibble per frame
        do_reset(32'h0, 8'h00, 1'b0);
        for (int n = 0; n < 16; n++) begin
            adv_to(32 * n);
            value = 32'(n);
            adv_to(32 * n + 3);
            chk($sformatf("hex%0h", n), seg, seg_tab[n]);
            chk($sformatf("hex%0h.com", n), com, 8'hFE);
        end

        // Asynchronous reset in the middle of a driven slot
        do_reset(32'h0000_1234, 8'h00, 1'b0);
        adv_to(20);
        chk_all("pre_rst", 8'hFB, 8'hA4, 3'd2, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'hFF, 8'hFF, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_cnt = 0;
        vq.push_back(mk(1, 8'hFF, 8'hFF, 3'd0, 1'b1));
        vq.push_back(mk(2, 8'hFF, 8'hFF, 3'd0, 1'b0));
        vq.push_back(mk(3, 8'hFE, 8'h99, 3'd0, 1'b0));
        vq.push_back(mk(9, 8'hFF, 8'hFF, 3'd1, 1'b0));
        run_vecs("restart");

        // Free-run: one-hot-or-idle commons and blank gap before each new digit
        do_reset(32'h0000_89AB, 8'h0F, 1'b0);
        begin
            logic [7:0] prev_com;
            int         gap;
            int         pop;
            prev_com = 8'hFF;
            gap      = 0;
            for (int c = 1; c <= 96; c++) begin
                adv_to(c);
                pop = $countones(~com);
                chk("onehot", 8'(pop > 1), 8'd0);
                if (com != 8'hFF && com != prev_com)
                    chk("gap", 8'(gap < 2), 8'd0);
                gap      = (com == 8'hFF) ? gap + 1 : 0;
                prev_com = com;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment (FND) display. It sequences a 3-bit digit index, inserts anti-ghosting blank time between digits and snapshots the display value once per frame so digits never tear. It decodes hex nibbles to active-low segments with optional leading-zero blanking. It sits between the counter/timer datapath (which supplies `i_value`) and the board FND pins.

## Interface
- `SCAN_DIV`, 100000: clocks per digit slot; must be ≥ 2.
- `BLANK_CYC`, 1000: blank clocks at the start of each slot; must satisfy 1 ≤ BLANK_CYC < SCAN_DIV.
- `DIGITS`, 8: active digits, 1..8; `o_com` bits ≥ DIGITS stay high.

Ports:
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_value`  in  32  nibble k (bits 4k+3:4k) is the hex value for digit k; digit 0 is the rightmost digit.
- `i_dp`  in  8  decimal point request per digit, 1 = lit.
- `i_lzb`  in  1  leading-zero blanking enable.
- `o_com`  out  8  digit commons, active-low, at most one bit low.
- `o_seg`  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- `o_digit_idx`  out  3  index of the current slot.
- `o_frame_start`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Internal slot counter `cnt` runs 0..SCAN_DIV-1. Internal `idx` runs 0..DIGITS-1.
- At cnt==SCAN_DIV-1, `cnt` returns to 0 and `idx` advances; after DIGITS-1 it wraps to 0.
- Two-state FSM per slot:
  - BLANK (cnt < BLANK_CYC): `o_com`=8'hFF, `o_seg`=8'hFF.
  - DRIVE (cnt ≥ BLANK_CYC): `o_com`=~(1<<idx), `o_seg`=decode(digit idx).
- Frame start is the slot edge where idx becomes 0, including the first edge after reset release.
  - At this edge, `i_value`, `i_dp` and `i_lzb` are sampled into snapshot registers.
  - All decode during the frame uses the snapshot only.
- Decode is hex, active-low segments g..a:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
  - dp bit = ~snap_dp[idx].
- Leading-zero blanking applies when snap_lzb=1, idx>0, and every snapshot nibble from DIGITS-1 down to idx is 0.
  - In that case segments g..a = 7'h7F; dp still follows snap_dp.
  - The common is still driven.
  - Digit 0 is never blanked.
- `o_digit_idx` = idx at all times, including during BLANK.

## Timing
- All outputs are registered and aligned with the counter state: the edge that moves cnt/idx also updates the outputs.
- Reset values: `o_com`=8'hFF, `o_seg`=8'hFF, `o_digit_idx`=0, `o_frame_start`=0, cnt=0, idx=0, snapshot=0.
- After reset release, edge 1 begins frame 0 / slot 0:
  - `o_frame_start`=1 for exactly that one cycle.
  - Edges 1..BLANK_CYC produce blank outputs.
  - Edges BLANK_CYC+1..SCAN_DIV drive digit 0.
  - Edge SCAN_DIV+1 starts slot 1 with blank.
- Frame period = DIGITS×SCAN_DIV clocks. `o_frame_start` period is exactly that.
- Changes to `i_value` mid-frame are invisible until the next frame start. A change coincident with the frame-start edge is captured.
- Reset asserted mid-slot forces all outputs to reset values immediately (asynchronously). Scanning restarts from frame 0 on release.
- Two low `o_com` bits never occur. Between consecutive driven digits there are always ≥ BLANK_CYC all-high `o_com` cycles.
- DIGITS=1: idx stays 0, and every slot is a frame start.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYC=2, DIGITS=4.
1. Reset release, `i_value`=32'h0000_1234, `i_dp`=0, `i_lzb`=0 → edges 1-2 `o_com`=FF; edges 3-8 `o_com`=FE, `o_seg`=99 ("4"). Slot 1 drives `o_com`=FD, `o_seg`=B0 ("3"). `o_frame_start` pulses on edges 1, 33, 65.
2. `i_value`=32'h0000_0007, `i_lzb`=1, `i_dp`=8'h02 → digit 0 `o_seg`=F8. Digit 1 `o_seg`=7F (blank with dp lit). Digits 2-3 `o_seg`=FF while the common is still low.
3. Change `i_value` from 32'h1111 to 32'h2222 at edge 10 → remainder of frame 0 shows F9 ("1"). Frame 1 (edges from 33) shows A4 ("2").
4. Apply every nibble 0-F on digit 0 → `o_seg` matches the decode list, with dp bit 1.
5. Assert `i_reset` at edge 20 (mid-DRIVE) for 3 cycles → outputs are FF/FF/0/0 immediately. After release, slot 0 resumes with 2 blank cycles and `o_frame_start`=1 on the first edge.
6. Free-run for 3 frames, checking every cycle → popcount(~`o_com`) ≤ 1, and ≥ 2 all-high cycles precede each new low `o_com`.
